// File: rtl/prog_loader.sv
// UART program loader: receives a framed, checksummed program on rx and writes it
// into the processor's instruction memory, holding the processor stalled until a verified load.
`timescale 1ns/1ps
module prog_loader #(
    parameter int CLKS_PER_BIT = 139,
    parameter int TIMEOUT_CLKS = 1600000,
    parameter int MEM_DEPTH    = 256
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rx,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_error,
    output logic [7:0] byte_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [8:0]       LEN_MAX   = 9'(MEM_DEPTH - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_WAIT_SYNC, P_GET_LEN, P_GET_DATA, P_GET_SUM} proto_state_t;

    // rx synchronizer and edge history; all reset to the idle (high) level
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    uart_state_t      u_state, u_state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             stop_wait, stop_wait_nxt;
    logic             byte_valid, byte_valid_nxt;
    logic             frame_err, frame_err_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            u_state    <= U_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            stop_wait  <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            u_state    <= u_state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            stop_wait  <= stop_wait_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        u_state_nxt    = u_state;
        bit_cnt_nxt    = bit_cnt;
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        stop_wait_nxt  = stop_wait;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        case (u_state)
            U_IDLE: begin
                bit_cnt_nxt   = '0;
                stop_wait_nxt = 1'b0;
                if (rx_prev && !rx_sync) u_state_nxt = U_START;
            end
            U_START: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    u_state_nxt = rx_sync ? U_IDLE : U_DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            U_DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = '0;
                    shreg_nxt   = {rx_sync, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) u_state_nxt = U_STOP;
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            U_STOP: begin
                // after a bad stop bit, hold here until the line returns high
                if (stop_wait) begin
                    if (rx_sync) u_state_nxt = U_IDLE;
                end else if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = '0;
                    if (rx_sync) begin
                        byte_valid_nxt = 1'b1;
                        u_state_nxt    = U_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        stop_wait_nxt = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            default: u_state_nxt = U_IDLE;
        endcase
    end

    proto_state_t    p_state, p_state_nxt;
    logic [7:0]      len, len_nxt;
    logic [7:0]      sum, sum_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            mem_we_nxt, cpu_hold_nxt, load_done_nxt, load_error_nxt;
    logic [7:0]      mem_addr_nxt, mem_wdata_nxt, byte_count_nxt;
    logic            proto_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_state    <= P_WAIT_SYNC;
            len        <= '0;
            sum        <= '0;
            to_cnt     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            byte_count <= '0;
        end else begin
            p_state    <= p_state_nxt;
            len        <= len_nxt;
            sum        <= sum_nxt;
            to_cnt     <= to_cnt_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            cpu_hold   <= cpu_hold_nxt;
            load_done  <= load_done_nxt;
            load_error <= load_error_nxt;
            byte_count <= byte_count_nxt;
        end
    end

    always_comb begin
        p_state_nxt    = p_state;
        len_nxt        = len;
        sum_nxt        = sum;
        mem_we_nxt     = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        cpu_hold_nxt   = cpu_hold;
        load_done_nxt  = 1'b0;
        load_error_nxt = load_error;
        byte_count_nxt = byte_count;
        proto_err      = 1'b0;
        if (p_state == P_WAIT_SYNC || byte_valid) to_cnt_nxt = '0;
        else to_cnt_nxt = to_cnt + TO_W'(1);

        case (p_state)
            P_WAIT_SYNC: begin
                if (byte_valid && shreg == SYNC_BYTE) begin
                    cpu_hold_nxt   = 1'b1;
                    load_error_nxt = 1'b0;
                    byte_count_nxt = '0;
                    sum_nxt        = '0;
                    p_state_nxt    = P_GET_LEN;
                end
            end
            P_GET_LEN: begin
                if (byte_valid) begin
                    if (shreg == 8'd0 || {1'b0, shreg} > LEN_MAX) begin
                        proto_err = 1'b1;
                    end else begin
                        len_nxt     = shreg;
                        p_state_nxt = P_GET_DATA;
                    end
                end
            end
            P_GET_DATA: begin
                // write strobe goes out first; count and checksum follow a cycle later
                if (mem_we) begin
                    byte_count_nxt = byte_count + 8'd1;
                    sum_nxt        = sum + mem_wdata;
                    if (byte_count + 8'd1 == len) p_state_nxt = P_GET_SUM;
                end else if (byte_valid) begin
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = byte_count;
                    mem_wdata_nxt = shreg;
                end
            end
            P_GET_SUM: begin
                if (byte_valid) begin
                    if (shreg == sum) begin
                        load_done_nxt = 1'b1;
                        cpu_hold_nxt  = 1'b0;
                        p_state_nxt   = P_WAIT_SYNC;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            default: p_state_nxt = P_WAIT_SYNC;
        endcase

        if (p_state != P_WAIT_SYNC && (frame_err || (!byte_valid && to_cnt == TO_LAST)))
            proto_err = 1'b1;

        if (proto_err) begin
            load_error_nxt = 1'b1;
            cpu_hold_nxt   = 1'b1;
            mem_we_nxt     = 1'b0;
            load_done_nxt  = 1'b0;
            p_state_nxt    = P_WAIT_SYNC;
        end
    end

endmodule
